// File: rtl/sar_control_4b.sv
// Successive-approximation controller: binary-searches the comparator's A operand one bit per
// clock, MSB first, with a start/done handshake and early exit on an exact match.
module sar_control_4b #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cmp_eq,
  input  logic         cmp_gt,
  output logic [N-1:0] trial,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  state_e          state;
  logic [IdxW-1:0] idx;

  logic            ge;
  logic [N-1:0]    msb_code;
  logic [N-1:0]    bit_idx;
  logic [N-1:0]    bit_below;
  logic [N-1:0]    kept;

  always_comb begin
    ge        = cmp_gt | cmp_eq;
    msb_code  = '0;
    msb_code[N-1] = 1'b1;
    bit_idx   = '0;
    bit_idx[idx] = 1'b1;
    bit_below = '0;
    if (idx != '0) begin
      bit_below[idx - 1'b1] = 1'b1;
    end
    // Keep the bit under test when A >= trial, otherwise drop it.
    kept = ge ? trial : (trial & ~bit_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= StIdle;
      trial  <= '0;
      result <= '0;
      idx    <= IdxTop;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            trial <= msb_code;
            idx   <= IdxTop;
            busy  <= 1'b1;
            state <= StConv;
          end
        end
        StConv: begin
          if (cmp_eq) begin
            result <= trial;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= StDone;
          end else if (idx == '0) begin
            result <= kept;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= StDone;
          end else begin
            trial <= kept | bit_below;
            idx   <= idx - 1'b1;
          end
        end
        StDone: begin
          done  <= 1'b0;
          idx   <= IdxTop;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          idx   <= IdxTop;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_control_4b.sv
// Bench for sar_control_4b: models the comparator against an unknown X and predicts each
// trial code from X directly (top bits of X followed by a single probe bit).
module tb_sar_control_4b;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cmp_eq;
  logic         cmp_gt;
  logic [N-1:0] trial;
  logic [N-1:0] result;
  logic         busy;
  logic         done;

  logic [N-1:0] x = '0;
  logic         force_gt = 1'b0;
  logic [N-1:0] exp_res = '0;

  int n_cmp = 0;
  int n_err = 0;

  sar_control_4b #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .trial  (trial),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  // Combinational comparator; force_gt creates the eq/gt conflict case.
  assign cmp_eq = (x == trial);
  assign cmp_gt = force_gt | (x > trial);

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed hang expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_result", 32'(result), 32'(exp_res));
  endtask

  // mode 0: start pulse; 1: start held high; 2: extra start pulse mid-conversion
  task automatic convert(input logic [N-1:0] xv, input int mode);
    logic [N-1:0] tr [1:N];
    int steps;
    bit found;
    int s;
    x = xv;
    steps = N;
    found = 1'b0;
    for (int j = 1; j <= N; j++) begin
      s = N - j + 1;
      tr[j] = N'(((int'(xv) >> s) << s) | (1 << (s - 1)));
      if (!found && tr[j] == xv) begin
        found = 1'b1;
        steps = j;
      end
    end
    start = 1'b1;
    tick();
    if (mode != 1) start = 1'b0;
    for (int j = 1; j <= steps; j++) begin
      chk($sformatf("trial_x%0h_s%0d", xv, j), 32'(trial), 32'(tr[j]));
      chk("conv_busy", 32'(busy), 32'd1);
      chk("conv_done", 32'(done), 32'd0);
      chk("conv_result_hold", 32'(result), 32'(exp_res));
      if (mode == 2) start = (j == 2);
      tick();
    end
    exp_res = xv;
    chk($sformatf("done_pulse_x%0h", xv), 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk($sformatf("result_x%0h", xv), 32'(result), 32'(xv));
    chk("done_trial_hold", 32'(trial), 32'(tr[steps]));
    tick();
    chk("after_done", 32'(done), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_result", 32'(result), 32'(xv));
  endtask

  initial begin
    logic [N-1:0] rx;
    int gap;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_trial", 32'(trial), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    chk_idle();
    chk("idle_trial", 32'(trial), 32'd0);

    // Directed conversions
    convert(4'h0, 0);
    tick();
    chk_idle();
    convert(4'hB, 0);
    convert(4'h8, 0);

    // Back-to-back with start held high; result holds 0x7 through the second conversion
    convert(4'h7, 1);
    convert(4'hF, 1);
    start = 1'b0;
    tick();
    chk_idle();

    // Start pulsed mid-conversion is not queued
    convert(4'h5, 2);
    tick();
    chk_idle();
    tick();
    chk_idle();

    // Reset at the second CONV edge aborts without a done pulse and clears result
    x = 4'hA;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_trial1", 32'(trial), 32'h8);
    tick();
    chk("abort_trial2", 32'(trial), 32'hC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_res = '0;
    chk("abort_trial", 32'(trial), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk_idle();
    tick();
    chk_idle();
    convert(4'hA, 0);

    // Conflicting eq and gt: eq must win and end the conversion on the first trial
    force_gt = 1'b1;
    convert(4'h8, 0);
    force_gt = 1'b0;

    // Randomized conversions with random idle gaps
    for (int r = 0; r < 24; r++) begin
      rx = N'($urandom_range(0, (1 << N) - 1));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        tick();
        chk_idle();
      end
      convert(rx, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
